// File: rtl/power_ctrl.sv
// Power-level controller: debounces the on/off buttons, requires a long on-press
// to power up, and drops power on an off-press or after an idle period.
module power_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
    parameter int unsigned ON_HOLD_CYCLES  = 100_000_000,
    parameter int unsigned IDLE_CYCLES     = 1_000_000_000,
    parameter int unsigned CNT_W           = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic power_on_btn,
    input  logic power_off_btn,
    input  logic activity,
    output logic power,
    output logic power_on_pulse
);

    typedef enum logic [1:0] {
        S_OFF,
        S_ARMING,
        S_ON,
        S_WAIT_REL
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(ON_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);

    // Bit 0 carries the on-button, bit 1 the off-button.
    logic [1:0]       sync1_q, sync2_q, deb_q;
    logic [CNT_W-1:0] deb_cnt_q [2];
    logic             deb_off_prev_q;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] idle_q, idle_d;
    logic             power_q, pulse_q;

    logic deb_on, deb_off, off_rise;

    assign deb_on   = deb_q[0];
    assign deb_off  = deb_q[1];
    assign off_rise = deb_off && !deb_off_prev_q;

    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q        <= '0;
            sync2_q        <= '0;
            deb_q          <= '0;
            deb_off_prev_q <= 1'b0;
            for (int i = 0; i < 2; i++) deb_cnt_q[i] <= '0;
        end else begin
            sync1_q        <= {power_off_btn, power_on_btn};
            sync2_q        <= sync1_q;
            deb_off_prev_q <= deb_q[1];
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] + CNT_ONE == DEB_LAST) begin
                    deb_q[i]     <= sync2_q[i];
                    deb_cnt_q[i] <= '0;
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        hold_d  = '0;
        idle_d  = '0;
        unique case (state_q)
            S_OFF: begin
                if (deb_on && !deb_off) state_d = S_ARMING;
            end
            S_ARMING: begin
                if (!deb_on || deb_off)            state_d = S_OFF;
                else if (hold_q + CNT_ONE == HOLD_LAST) state_d = S_ON;
                else                               hold_d  = hold_q + CNT_ONE;
            end
            S_ON: begin
                // Off-press and idle timeout collapse into one transition.
                if (off_rise)                state_d = S_WAIT_REL;
                else if (activity)           idle_d  = '0;
                else if (idle_q == IDLE_LAST) state_d = S_WAIT_REL;
                else                         idle_d  = idle_q + CNT_ONE;
            end
            S_WAIT_REL: begin
                if (!deb_on && !deb_off) state_d = S_OFF;
            end
            default: state_d = S_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_OFF;
            hold_q  <= '0;
            idle_q  <= '0;
            power_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idle_q  <= idle_d;
            power_q <= (state_d == S_ON);
            pulse_q <= (state_d == S_ON) && (state_q != S_ON);
        end
    end

    assign power          = power_q;
    assign power_on_pulse = pulse_q;

endmodule

// File: tb/tb_power_ctrl.sv
// Self-checking bench for power_ctrl: directed scenarios with literal timing
// expectations plus randomized stimulus, all compared against an event-level model.
module tb_power_ctrl;

    localparam int D = 4;
    localparam int H = 10;
    localparam int I = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic on_btn = 1'b0;
    logic off_btn = 1'b0;
    logic activity = 1'b0;
    logic power;
    logic pulse;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    power_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .ON_HOLD_CYCLES (H),
        .IDLE_CYCLES    (I),
        .CNT_W          (30)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .power_on_btn  (on_btn),
        .power_off_btn (off_btn),
        .activity      (activity),
        .power         (power),
        .power_on_pulse(pulse)
    );

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a button's debounced value flips once the last D synchronized
    // samples all disagree with it; the FSM is tracked with edge time stamps.
    typedef enum {M_OFF, M_ARM, M_ON, M_WAIT} mstate_e;

    mstate_e m_state = M_OFF;
    bit      m_valid = 1'b0;
    int      edge_n = 0;
    int      arm_entry = 0;
    int      clear_edge = 0;
    bit      hist_on[$];
    bit      hist_off[$];
    bit      m_deb_on = 1'b0;
    bit      m_deb_off = 1'b0;
    bit      m_off_old = 1'b0;
    bit      m_power = 1'b0;
    bit      m_pulse = 1'b0;

    function automatic bit window_disagrees(input bit h[$], input bit deb);
        for (int k = 2; k <= D + 1; k++) if (h[k] == deb) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step();
        mstate_e prev;
        bit      rise;
        edge_n++;
        if (rst) begin
            m_valid = 1'b1;
            m_state = M_OFF;
            hist_on = {};
            hist_off = {};
            for (int k = 0; k < D + 2; k++) begin
                hist_on.push_back(1'b0);
                hist_off.push_back(1'b0);
            end
            m_deb_on  = 1'b0;
            m_deb_off = 1'b0;
            m_off_old = 1'b0;
            m_power   = 1'b0;
            m_pulse   = 1'b0;
            return;
        end
        if (!m_valid) return;
        prev = m_state;
        rise = m_deb_off && !m_off_old;
        case (m_state)
            M_OFF: if (m_deb_on && !m_deb_off) begin
                m_state = M_ARM;
                arm_entry = edge_n;
            end
            M_ARM: begin
                if (!m_deb_on || m_deb_off) m_state = M_OFF;
                else if (edge_n - arm_entry == H - 1) begin
                    m_state = M_ON;
                    clear_edge = edge_n;
                end
            end
            M_ON: begin
                if (rise) m_state = M_WAIT;
                else if (activity) clear_edge = edge_n;
                else if (edge_n - clear_edge == I) m_state = M_WAIT;
            end
            M_WAIT: if (!m_deb_on && !m_deb_off) m_state = M_OFF;
            default: m_state = M_OFF;
        endcase
        m_off_old = m_deb_off;
        hist_on.push_front(on_btn);
        void'(hist_on.pop_back());
        hist_off.push_front(off_btn);
        void'(hist_off.pop_back());
        if (window_disagrees(hist_on, m_deb_on))   m_deb_on  = !m_deb_on;
        if (window_disagrees(hist_off, m_deb_off)) m_deb_off = !m_deb_off;
        m_power = (m_state == M_ON);
        m_pulse = m_power && (prev != M_ON);
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        if (m_valid) begin
            check("model_power", power, m_power);
            check("model_pulse", pulse, m_pulse);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_n(input int n);
        repeat (n) tick();
    endtask

    // Full long press from an idle OFF state; power must rise exactly 16 cycles later.
    task automatic power_up(input string tag);
        on_btn = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 15) check({tag, "_pwr15"}, power, 1'b0);
            if (k == 16) begin
                check({tag, "_pwr16"}, power, 1'b1);
                check({tag, "_pulse16"}, pulse, 1'b1);
            end
        end
        on_btn = 1'b0;
    endtask

    initial begin
        int seg_on;
        int seg_off;
        int act_pct;

        idle_n(3);
        check("reset_power", power, 1'b0);
        check("reset_pulse", pulse, 1'b0);
        rst = 1'b0;
        idle_n(10);

        // Long press, then idle timeout 20 cycles after entering ON.
        on_btn = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            tick();
            if (k <= 15) check("lp_power_low", power, 1'b0);
            if (k == 16) begin
                check("lp_power16", power, 1'b1);
                check("lp_pulse16", pulse, 1'b1);
            end
            if (k == 17) begin
                check("lp_power17", power, 1'b1);
                check("lp_pulse17", pulse, 1'b0);
                on_btn = 1'b0;
            end
            if (k == 35) check("idle_power35", power, 1'b1);
            if (k == 36) check("idle_power36", power, 1'b0);
        end
        idle_n(10);

        // Single activity on idle cycle 19 extends power by another 20 cycles.
        power_up("ext");
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 19) activity = 1'b1;
            if (k == 20) begin
                activity = 1'b0;
                check("ext_power20", power, 1'b1);
            end
            if (k == 39) check("ext_power39", power, 1'b1);
            if (k == 40) check("ext_power40", power, 1'b0);
        end
        idle_n(10);

        // Off press while active, with the on-button held afterwards.
        power_up("offp");
        for (int k = 1; k <= 60; k++) begin
            tick();
            activity = (k % 5 == 0);
            if (k == 3)  off_btn = 1'b1;
            if (k == 5)  on_btn = 1'b1;
            if (k == 9)  check("off_power9", power, 1'b1);
            if (k == 10) check("off_power10", power, 1'b0);
            if (k == 13) off_btn = 1'b0;
            if (k == 60) check("off_hold_power", power, 1'b0);
        end
        on_btn = 1'b0;
        activity = 1'b0;
        idle_n(20);
        power_up("offre");
        idle_n(25);

        // Short press of 8 cycles never powers up.
        on_btn = 1'b1;
        idle_n(8);
        on_btn = 1'b0;
        for (int k = 9; k <= 40; k++) begin
            tick();
            check("short_power", power, 1'b0);
        end
        idle_n(5);
        power_up("short_re");
        idle_n(25);

        // Bounce: toggle every 2 cycles for 40 cycles.
        for (int k = 0; k < 40; k++) begin
            on_btn = ((k / 2) % 2 == 0);
            tick();
            check("bounce_power", power, 1'b0);
        end
        on_btn = 1'b0;
        idle_n(10);
        power_up("bounce_re");
        idle_n(25);

        // Reset while ON.
        power_up("rst_on");
        idle_n(3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_on_power", power, 1'b0);
        check("rst_on_pulse", pulse, 1'b0);
        idle_n(10);
        power_up("rst_on_re");
        idle_n(25);

        // Reset while ARMING with the button kept held: a full new press is needed.
        on_btn = 1'b1;
        idle_n(10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_arm_power", power, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 15) check("rst_arm_power15", power, 1'b0);
            if (k == 16) check("rst_arm_power16", power, 1'b1);
        end
        on_btn = 1'b0;
        idle_n(25);

        // Randomized stimulus, checked every cycle by the model.
        seg_on = 0;
        seg_off = 0;
        act_pct = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) begin
                case ($urandom_range(0, 2))
                    0:       act_pct = 0;
                    1:       act_pct = 3;
                    default: act_pct = 30;
                endcase
            end
            if (seg_on == 0) begin
                on_btn = ($urandom_range(0, 9) < 6);
                seg_on = $urandom_range(1, 40);
            end
            if (seg_off == 0) begin
                off_btn = ($urandom_range(0, 9) < 2);
                seg_off = $urandom_range(1, 40);
            end
            seg_on--;
            seg_off--;
            activity = ($urandom_range(0, 99) < act_pct);
            rst = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst = 1'b0;
        idle_n(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
